ifu_redirect_ctrl: RTL

- Control-transfer resolver that drives the IFU's redirect inputs for MIPS branches and jumps with one architectural delay slot.
- Decodes the instruction the IFU presents and resolves the branch condition from register-file read data.
- Holds the absolute target for one delay-slot cycle, then issues the redirect to the IFU as an absolute register jump.
- Sits between the IFU output (Instr, PC+4), the GRF read ports and the IFU control inputs; also produces the link write for jal/jalr.

---
 rtl/ifu_redirect_ctrl_pkg.sv | 32 +++
 rtl/ifu_cti_decode.sv | 70 +++++++
 rtl/ifu_redirect_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ifu_redirect_ctrl_pkg.sv
// Shared encodings for the IFU redirect controller: IFU control codes, MIPS
// opcode/funct values, FSM states and the branch-offset helper.
package ifu_redirect_ctrl_pkg;

  localparam logic [1:0] IFU_NORMAL = 2'b00;
  localparam logic [1:0] IFU_BRANCH = 2'b01;
  localparam logic [1:0] IFU_JUMP   = 2'b10;
  localparam logic [1:0] IFU_JREG   = 2'b11;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] LINK_REG_RA = 5'd31;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_SLOT = 1'b1
  } state_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_cti_decode.sv
// Combinational decode of a fetched instruction into control-transfer info:
// whether it is a CTI, whether it is taken, its absolute target and its link write.
module ifu_cti_decode
  import ifu_redirect_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        is_cti_o,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        link_we_o,
  output logic [4:0]  link_addr_o
);

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rd_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;
  logic        rs_zero_s;

  assign opcode_s    = instr_i[31:26];
  assign funct_s     = instr_i[5:0];
  assign rd_s        = instr_i[15:11];
  assign br_target_s = pc_plus4_i + branch_offset(instr_i[15:0]);
  assign j_target_s  = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
  assign rs_zero_s   = (rs_data_i == 32'd0);

  // Opcode/funct decode; branch conditions use rs sign bit for signed compares against zero
  always_comb begin
    is_cti_o    = 1'b0;
    taken_o     = 1'b0;
    target_o    = 32'd0;
    link_we_o   = 1'b0;
    link_addr_o = 5'd0;
    case (opcode_s)
      OP_BEQ:  begin is_cti_o = 1'b1; taken_o = (rs_data_i == rt_data_i); target_o = br_target_s; end
      OP_BNE:  begin is_cti_o = 1'b1; taken_o = (rs_data_i != rt_data_i); target_o = br_target_s; end
      OP_BLEZ: begin is_cti_o = 1'b1; taken_o = rs_data_i[31] | rs_zero_s; target_o = br_target_s; end
      OP_BGTZ: begin is_cti_o = 1'b1; taken_o = ~rs_data_i[31] & ~rs_zero_s; target_o = br_target_s; end
      OP_J:    begin is_cti_o = 1'b1; taken_o = 1'b1; target_o = j_target_s; end
      OP_JAL: begin
        is_cti_o    = 1'b1;
        taken_o     = 1'b1;
        target_o    = j_target_s;
        link_we_o   = 1'b1;
        link_addr_o = LINK_REG_RA;
      end
      OP_SPECIAL: begin
        if (funct_s == FN_JR) begin
          is_cti_o = 1'b1;
          taken_o  = 1'b1;
          target_o = rs_data_i;
        end else if (funct_s == FN_JALR) begin
          is_cti_o    = 1'b1;
          taken_o     = 1'b1;
          target_o    = rs_data_i;
          link_addr_o = rd_s;
          link_we_o   = (rd_s != 5'd0);
        end else begin
          is_cti_o = 1'b0;
        end
      end
      default: is_cti_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ifu_redirect_ctrl.sv
// Delay-slot redirect controller: latches the CTI decision, then holds an
// absolute-register redirect to the IFU for the delay-slot cycle.
module ifu_redirect_ctrl
  import ifu_redirect_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [31:0] IFU_PC_plus_4,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  output logic [1:0]  IFU_Control,
  output logic [31:0] IFU_RegAddr,
  output logic        in_dslot,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic        dslot_err
);

  state_e      state_q, state_d;
  logic        pend_taken_q, pend_taken_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        link_we_q, link_we_d;
  logic [4:0]  link_addr_q, link_addr_d;
  logic [31:0] link_data_q, link_data_d;
  logic        dslot_err_q, dslot_err_d;

  logic        dec_is_cti_s, dec_taken_s, dec_link_we_s;
  logic [31:0] dec_target_s;
  logic [4:0]  dec_link_addr_s;
  logic        capture_s, slot_cti_s;

  ifu_cti_decode u_decode (
    .instr_i     (Instr),
    .pc_plus4_i  (IFU_PC_plus_4),
    .rs_data_i   (rs_data),
    .rt_data_i   (rt_data),
    .is_cti_o    (dec_is_cti_s),
    .taken_o     (dec_taken_s),
    .target_o    (dec_target_s),
    .link_we_o   (dec_link_we_s),
    .link_addr_o (dec_link_addr_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a CTI seen in the slot is flagged, never decoded
  always_comb begin
    state_d    = state_q;
    capture_s  = 1'b0;
    slot_cti_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!stall && dec_is_cti_s) begin
          state_d   = ST_SLOT;
          capture_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SLOT: begin
        if (!stall) begin
          state_d    = ST_RUN;
          slot_cti_s = dec_is_cti_s;
        end else begin
          state_d = ST_SLOT;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Moore outputs
  always_comb begin
    if (state_q == ST_SLOT && pend_taken_q) begin
      IFU_Control = IFU_JREG;
    end else begin
      IFU_Control = IFU_NORMAL;
    end
    in_dslot = (state_q == ST_SLOT);
  end

  // Pending decision and link capture; the two strobes self-clear even under stall
  always_comb begin
    pend_taken_d  = pend_taken_q;
    pend_target_d = pend_target_q;
    link_addr_d   = link_addr_q;
    link_data_d   = link_data_q;
    link_we_d     = 1'b0;
    dslot_err_d   = slot_cti_s;
    if (capture_s) begin
      pend_taken_d  = dec_taken_s;
      pend_target_d = dec_target_s;
      link_we_d     = dec_link_we_s;
      link_addr_d   = dec_link_addr_s;
      link_data_d   = IFU_PC_plus_4 + 32'd4;
    end else begin
      link_we_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_taken_q  <= 1'b0;
      pend_target_q <= 32'd0;
      link_we_q     <= 1'b0;
      link_addr_q   <= 5'd0;
      link_data_q   <= 32'd0;
      dslot_err_q   <= 1'b0;
    end else begin
      pend_taken_q  <= pend_taken_d;
      pend_target_q <= pend_target_d;
      link_we_q     <= link_we_d;
      link_addr_q   <= link_addr_d;
      link_data_q   <= link_data_d;
      dslot_err_q   <= dslot_err_d;
    end
  end

  assign IFU_RegAddr = pend_target_q;
  assign link_we     = link_we_q;
  assign link_addr   = link_addr_q;
  assign link_data   = link_data_q;
  assign dslot_err   = dslot_err_q;

endmodule
